// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line evaluator.
// Holds the object RAM word field offsets, the word select values used in
// the object RAM address, the tile height constant and the FSM state type.
package sprite_pkg;

  // Object pixel rows are grouped into 8-line tiles
  localparam int TILE_PX    = 8;
  localparam int TILE_SHIFT = $clog2(TILE_PX);

  // Y word: {size_x, size_y, hflip, vflip, z, active, y}
  localparam int YW_Y_LSB      = 0;
  localparam int YW_ACTIVE     = 16;
  localparam int YW_Z_LSB      = 17;
  localparam int YW_VFLIP      = 19;
  localparam int YW_HFLIP      = 20;
  localparam int YW_SIZE_Y_LSB = 21;
  localparam int YW_SIZE_X_LSB = 24;

  // X word: {palette, table, tile_x, tile_y, x}
  localparam int XW_X_LSB      = 0;
  localparam int XW_TILE_Y_LSB = 16;
  localparam int XW_TILE_X_LSB = 20;
  localparam int XW_TABLE      = 24;
  localparam int XW_PAL_LSB    = 25;

  // Low bit of the object RAM address selects the word within an object
  localparam logic WORD_Y = 1'b0;
  localparam logic WORD_X = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_Y,
    ST_FETCH_X,
    ST_EVAL,
    ST_EMIT,
    ST_NEXT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sprite_row_test.sv
// Combinational intersect test of one object against a scanline.
// Ports:
//   line_y   - scanline being evaluated
//   y_word   - object Y word (position, height code, flips, active)
//   tile_y   - object tile row base from the X word
//   hit      - object is active and covers line_y
//   tile_row - tile row to fetch (tile_y + row/8, wraps mod 16)
//   pix_row  - pixel row inside that tile
module sprite_row_test
  import sprite_pkg::*;
#(
  parameter int Y_W = 10
) (
  input  logic [Y_W-1:0] line_y,
  input  logic [31:0]    y_word,
  input  logic [3:0]     tile_y,
  output logic           hit,
  output logic [3:0]     tile_row,
  output logic [2:0]     pix_row
);

  logic [2:0]  size_y;
  logic [6:0]  height;
  logic [15:0] d;
  logic [6:0]  row;
  logic        unused_fields;

  // Fields of the Y word that only matter for the emitted command
  assign unused_fields = ^{y_word[31:24], y_word[YW_HFLIP], y_word[YW_Z_LSB +: 2]};

  // The line offset wraps in 16 bits, so objects above the top edge
  // (large y) still intersect the first lines of the screen.
  // A vertically flipped object reads its rows bottom-up.
  always_comb begin
    size_y   = y_word[YW_SIZE_Y_LSB +: 3];
    height   = ({4'd0, size_y} + 7'd1) << TILE_SHIFT;
    d        = 16'(line_y) - y_word[YW_Y_LSB +: 16];
    hit      = y_word[YW_ACTIVE] && (d < {9'd0, height});
    row      = y_word[YW_VFLIP] ? (height - 7'd1 - d[6:0]) : d[6:0];
    tile_row = tile_y + row[6:3];
    pix_row  = row[2:0];
  end

endmodule

// File: rtl/sprite_line_evaluator.sv
// Per-scanline sprite evaluator.
// Walks the whole object table once per line, starting at a rotating
// priority index, and emits one load command per intersecting object to
// the line buffer over a valid/ready handshake.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   line_start        - restart evaluation for line_y from prio_start
//   scan_en           - advance enable; low freezes the evaluator
//   obj_addr/obj_data - object RAM read port ({index, word}, 1-cycle latency)
//   cmd_*             - load command to the line buffer (valid/ready)
//   busy, done        - scan in progress / scan finished for this line
//   overflow          - more hits than MAX_PER_LINE on this line
//   hit_count         - commands transferred on this line
module sprite_line_evaluator
  import sprite_pkg::*;
#(
  parameter int SPRITE_COUNT = 256,
  parameter int IDX_W        = 8,
  parameter int MAX_PER_LINE = 32,
  parameter int Y_W          = 10,
  localparam int HC_W        = $clog2(MAX_PER_LINE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             line_start,
  input  logic             scan_en,
  input  logic [Y_W-1:0]   line_y,
  input  logic [IDX_W-1:0] prio_start,
  output logic [IDX_W:0]   obj_addr,
  input  logic [31:0]      obj_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [9:0]       cmd_x,
  output logic [2:0]       cmd_size_x,
  output logic             cmd_hflip,
  output logic [1:0]       cmd_z,
  output logic [4:0]       cmd_palette,
  output logic             cmd_table,
  output logic [3:0]       cmd_tile_x,
  output logic [3:0]       cmd_tile_row,
  output logic [2:0]       cmd_pix_row,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [HC_W-1:0]  hit_count
);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   visited;
  logic [Y_W-1:0]   line_q;
  logic [31:0]      y_word;
  logic             fetch_y_q;
  logic             hit;
  logic [3:0]       tile_row;
  logic [2:0]       pix_row;
  logic             at_limit;
  logic             last_visit;

  sprite_row_test #(.Y_W(Y_W)) u_row_test (
    .line_y   (line_q),
    .y_word   (y_word),
    .tile_y   (obj_data[XW_TILE_Y_LSB +: 4]),
    .hit      (hit),
    .tile_row (tile_row),
    .pix_row  (pix_row)
  );

  assign at_limit   = (hit_count == HC_W'(MAX_PER_LINE));
  assign last_visit = (visited == (IDX_W+1)'(SPRITE_COUNT - 1));

  assign cmd_valid = (state == ST_EMIT);
  assign done      = (state == ST_DONE);
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);

  // The X address is held through EVAL so the RAM keeps returning the
  // X word while the evaluator is frozen there.
  always_comb begin
    obj_addr = {idx, WORD_Y};
    case (state)
      ST_FETCH_X, ST_EVAL: obj_addr = {idx, WORD_X};
      default:             obj_addr = {idx, WORD_Y};
    endcase
  end

  // Next state; line_start restarts from any state
  always_comb begin
    state_n = state;
    if (scan_en) begin
      if (line_start) begin
        state_n = ST_FETCH_Y;
      end else begin
        case (state)
          ST_FETCH_Y: state_n = ST_FETCH_X;
          ST_FETCH_X: state_n = ST_EVAL;
          ST_EVAL: begin
            if (hit) state_n = at_limit ? ST_DONE : ST_EMIT;
            else     state_n = ST_NEXT;
          end
          ST_EMIT:    if (cmd_ready) state_n = ST_NEXT;
          ST_NEXT:    state_n = last_visit ? ST_DONE : ST_FETCH_Y;
          default:    state_n = state;
        endcase
      end
    end
  end

  // The Y word is captured on the first FETCH_X cycle only, i.e. when the
  // previous cycle addressed it; a freeze in FETCH_X already moves the
  // address to the X word, so later cycles must not overwrite it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      visited      <= '0;
      line_q       <= '0;
      y_word       <= '0;
      fetch_y_q    <= 1'b0;
      hit_count    <= '0;
      overflow     <= 1'b0;
      cmd_x        <= '0;
      cmd_size_x   <= '0;
      cmd_hflip    <= 1'b0;
      cmd_z        <= '0;
      cmd_palette  <= '0;
      cmd_table    <= 1'b0;
      cmd_tile_x   <= '0;
      cmd_tile_row <= '0;
      cmd_pix_row  <= '0;
    end else begin
      fetch_y_q <= (state == ST_FETCH_Y);
      if (state == ST_FETCH_X && fetch_y_q) y_word <= obj_data;
      if (scan_en) begin
        state <= state_n;
        if (line_start) begin
          idx       <= prio_start;
          visited   <= '0;
          hit_count <= '0;
          overflow  <= 1'b0;
          line_q    <= line_y;
        end else begin
          case (state)
            ST_EVAL: begin
              if (hit && at_limit) begin
                overflow <= 1'b1;
              end else if (hit) begin
                cmd_x        <= obj_data[XW_X_LSB +: 10];
                cmd_size_x   <= y_word[YW_SIZE_X_LSB +: 3];
                cmd_hflip    <= y_word[YW_HFLIP];
                cmd_z        <= y_word[YW_Z_LSB +: 2];
                cmd_palette  <= obj_data[XW_PAL_LSB +: 5];
                cmd_table    <= obj_data[XW_TABLE];
                cmd_tile_x   <= obj_data[XW_TILE_X_LSB +: 4];
                cmd_tile_row <= tile_row;
                cmd_pix_row  <= pix_row;
              end
            end
            ST_EMIT: if (cmd_ready) hit_count <= hit_count + HC_W'(1);
            ST_NEXT: begin
              idx     <= idx + IDX_W'(1);
              visited <= visited + (IDX_W+1)'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_evaluator.sv
// Self-checking bench for sprite_line_evaluator: an object RAM with one
// cycle read latency, and a reference model that walks the table in
// priority order and decodes each object with plain arithmetic.
module tb_sprite_line_evaluator;

  localparam int SC   = 256;
  localparam int IW   = 8;
  localparam int MAXL = 32;
  localparam int YW   = 10;
  localparam int HCW  = $clog2(MAXL + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            line_start;
  logic            scan_en;
  logic [YW-1:0]   line_y;
  logic [IW-1:0]   prio_start;
  logic [IW:0]     obj_addr;
  logic [31:0]     obj_data;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [9:0]      cmd_x;
  logic [2:0]      cmd_size_x;
  logic            cmd_hflip;
  logic [1:0]      cmd_z;
  logic [4:0]      cmd_palette;
  logic            cmd_table;
  logic [3:0]      cmd_tile_x;
  logic [3:0]      cmd_tile_row;
  logic [2:0]      cmd_pix_row;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [HCW-1:0]  hit_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ram [0:2*SC-1];
  logic [32:0] obs_q[$];
  logic [32:0] exp_q[$];
  bit          exp_ovf;
  int          stable_errs = 0;
  logic [32:0] prev_cmd;
  bit          prev_pending = 0;
  logic [32:0] cur_cmd;
  logic [63:0] all_out;

  sprite_line_evaluator #(
    .SPRITE_COUNT(SC), .IDX_W(IW), .MAX_PER_LINE(MAXL), .Y_W(YW)
  ) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .scan_en(scan_en),
    .line_y(line_y), .prio_start(prio_start), .obj_addr(obj_addr),
    .obj_data(obj_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_size_x(cmd_size_x), .cmd_hflip(cmd_hflip),
    .cmd_z(cmd_z), .cmd_palette(cmd_palette), .cmd_table(cmd_table),
    .cmd_tile_x(cmd_tile_x), .cmd_tile_row(cmd_tile_row),
    .cmd_pix_row(cmd_pix_row), .busy(busy), .done(done),
    .overflow(overflow), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // Object RAM with one cycle read latency
  always @(posedge clk) obj_data <= ram[obj_addr];

  assign cur_cmd = {cmd_x, cmd_size_x, cmd_hflip, cmd_z, cmd_palette,
                    cmd_table, cmd_tile_x, cmd_tile_row, cmd_pix_row};
  assign all_out = {obj_addr, cmd_valid, cur_cmd, busy, done, overflow, hit_count,
                    {(64-IW-1-1-33-3-HCW){1'b0}}};

  // Records every command the line buffer accepts and counts any change of
  // command fields while a command is waiting to be accepted
  always @(negedge clk) begin
    if (prev_pending && cmd_valid && cur_cmd !== prev_cmd) stable_errs++;
    if (cmd_valid && cmd_ready && scan_en && !line_start && !rst) begin
      obs_q.push_back(cur_cmd);
      prev_pending = 0;
    end else begin
      prev_pending = cmd_valid;
    end
    prev_cmd = cur_cmd;
  end

  function automatic logic [31:0] make_y(input int y, input int active, input int vflip,
                                         input int hflip, input int z, input int size_y,
                                         input int size_x);
    return (32'(size_x & 7) << 24) | (32'(size_y & 7) << 21) | (32'(hflip & 1) << 20) |
           (32'(vflip & 1) << 19) | (32'(z & 3) << 17) | (32'(active & 1) << 16) |
           32'(y & 'hFFFF);
  endfunction

  function automatic logic [31:0] make_x(input int x, input int tile_y, input int tile_x,
                                         input int tbl, input int pal);
    return (32'(pal & 31) << 25) | (32'(tbl & 1) << 24) | (32'(tile_x & 15) << 20) |
           (32'(tile_y & 15) << 16) | 32'(x & 'hFFFF);
  endfunction

  task automatic clear_table();
    for (int k = 0; k < 2*SC; k++) ram[k] = 32'h0;
  endtask

  // Random table where about a quarter of objects are active and half of
  // those are placed close above line ly
  task automatic gen_table(input int ly);
    logic [31:0] r;
    int y;
    for (int k = 0; k < SC; k++) begin
      r = $urandom();
      if ($urandom_range(0, 1) == 1) y = (ly - int'($urandom_range(0, 80))) & 'hFFFF;
      else y = int'($urandom_range(0, 'hFFFF));
      ram[2*k] = make_y(y, ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
                        int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 7)), int'($urandom_range(0, 7)))
                 | (r & 32'hF800_0000);
      ram[2*k+1] = $urandom();
    end
  endtask

  // Reference: visit every object once from prio, wrapping through 0
  task automatic model_scan(input int ly, input int prio);
    logic [31:0] yw, xw;
    int idx, h, d, row, trow;
    exp_q.delete();
    exp_ovf = 0;
    for (int k = 0; k < SC; k++) begin
      idx = (prio + k) % SC;
      yw  = ram[2*idx];
      xw  = ram[2*idx+1];
      if (((yw >> 16) & 1) == 0) continue;
      h = 8 * (int'((yw >> 21) & 7) + 1);
      d = (ly - int'(yw & 32'hFFFF)) & 'hFFFF;
      if (d >= h) continue;
      if (exp_q.size() == MAXL) begin
        exp_ovf = 1;
        break;
      end
      row  = (((yw >> 19) & 1) == 1) ? (h - 1 - d) : d;
      trow = (int'((xw >> 16) & 15) + row / 8) % 16;
      exp_q.push_back({10'(xw & 1023), 3'((yw >> 24) & 7), 1'((yw >> 20) & 1),
                       2'((yw >> 17) & 3), 5'((xw >> 25) & 31), 1'((xw >> 24) & 1),
                       4'((xw >> 20) & 15), 4'(trow), 3'(row % 8)});
    end
  endtask

  task automatic start_line(input int ly, input int prio);
    @(posedge clk); #1;
    line_y     = YW'(ly);
    prio_start = IW'(prio);
    line_start = 1'b1;
    obs_q.delete();
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  // Mode 0 keeps cmd_ready high, mode 1 randomises it every cycle
  task automatic wait_done(input int mode, output int cycles, output bit to);
    cycles = 0;
    to = 0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      if (cycles == 6000) begin
        to = 1;
        break;
      end
      cycles++;
      @(posedge clk); #1;
      cmd_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic wait_valid(output bit to);
    to = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (cmd_valid) begin
        to = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; line_start = 1'b0; scan_en = 1'b1; cmd_ready = 1'b1;
    line_y = '0; prio_start = '0;
    clear_table();
    #3;
    n_checks++;
    if (all_out !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_async: outputs=%h required=0", all_out);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (all_out !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: outputs=%h required=0", all_out);
    end
  endtask

  task automatic test_single_hit();
    int cyc; bit to;
    clear_table();
    ram[0] = make_y(100, 1, 0, 1, 2, 1, 3);
    ram[1] = make_x(321, 5, 9, 1, 17);
    model_scan(107, 0);
    cmd_ready = 1'b1;
    start_line(107, 0);
    wait_done(0, cyc, to);
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL single_timeout: done never rose"); end
    n_checks++;
    if (cyc != 4*SC + 1) begin
      n_fail++;
      $display("[TB] FAIL single_cycles: got %0d required %0d", cyc, 4*SC + 1);
    end
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL single_count: got %0d required 1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      n_checks++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("[TB] FAIL single_cmd: got %h required %h", obs_q[0], exp_q[0]);
      end
      n_checks++;
      if (obs_q[0][6:0] !== {4'd5, 3'd7}) begin
        n_fail++;
        $display("[TB] FAIL single_rows: tile_row/pix_row got %0d/%0d required 5/7",
                 obs_q[0][6:3], obs_q[0][2:0]);
      end
    end
    n_checks++;
    if ({busy, overflow, hit_count} !== {1'b0, 1'b0, HCW'(1)}) begin
      n_fail++;
      $display("[TB] FAIL single_status: busy=%0d overflow=%0d hit_count=%0d required 0/0/1",
               busy, overflow, hit_count);
    end
  endtask

  task automatic test_vflip();
    int cyc; bit to;
    clear_table();
    ram[0] = make_y(100, 1, 1, 0, 0, 1, 0);
    ram[1] = make_x(40, 5, 2, 0, 3);
    start_line(100, 0);
    wait_done(0, cyc, to);
    n_checks++;
    if (to || obs_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL vflip_count: got %0d commands (timeout=%0d) required 1", obs_q.size(), to);
    end
    if (obs_q.size() > 0) begin
      n_checks++;
      if (obs_q[0][6:0] !== {4'd6, 3'd7}) begin
        n_fail++;
        $display("[TB] FAIL vflip_rows: tile_row/pix_row got %0d/%0d required 6/7",
                 obs_q[0][6:3], obs_q[0][2:0]);
      end
    end
    start_line(116, 0);
    wait_done(0, cyc, to);
    n_checks++;
    if (to || obs_q.size() != 0 || hit_count !== '0) begin
      n_fail++;
      $display("[TB] FAIL vflip_miss: got %0d commands hit_count=%0d required 0/0",
               obs_q.size(), hit_count);
    end
  endtask

  task automatic test_overflow();
    bit used[SC];
    int cnt, idx, prio, cyc; bit to;
    clear_table();
    cnt = 0;
    while (cnt < 40) begin
      idx = int'($urandom_range(0, SC-1));
      if (!used[idx]) begin
        used[idx] = 1;
        cnt++;
        ram[2*idx]   = make_y(500 - int'($urandom_range(0, 7)), 1, int'($urandom_range(0, 1)), 0,
                              1, int'($urandom_range(0, 7)), 2);
        ram[2*idx+1] = make_x(idx, int'($urandom_range(0, 15)), 1, 0, 4);
      end
    end
    prio = int'($urandom_range(0, SC-1));
    model_scan(500, prio);
    start_line(500, prio);
    wait_done(0, cyc, to);
    n_checks++;
    if (to || obs_q.size() != MAXL) begin
      n_fail++;
      $display("[TB] FAIL ovf_count: got %0d commands required %0d", obs_q.size(), MAXL);
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("[TB] FAIL ovf_cmd[%0d]: got %h required %h", k, obs_q[k], exp_q[k]);
      end
    end
    n_checks++;
    if (overflow !== 1'b1 || hit_count !== HCW'(MAXL)) begin
      n_fail++;
      $display("[TB] FAIL ovf_status: overflow=%0d hit_count=%0d required 1/%0d",
               overflow, hit_count, MAXL);
    end
  endtask

  task automatic test_wrap();
    int cyc; bit to;
    clear_table();
    ram[2*255]   = make_y(300, 1, 0, 0, 0, 0, 0);
    ram[2*255+1] = make_x(11, 0, 0, 0, 0);
    ram[0]       = make_y(298, 1, 0, 0, 0, 0, 0);
    ram[1]       = make_x(22, 0, 0, 0, 0);
    start_line(302, 254);
    wait_done(0, cyc, to);
    n_checks++;
    if (to || cyc != 4*SC + 2) begin
      n_fail++;
      $display("[TB] FAIL wrap_cycles: got %0d (timeout=%0d) required %0d", cyc, to, 4*SC + 2);
    end
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("[TB] FAIL wrap_count: got %0d required 2", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0][32:23] !== 10'd11 || obs_q[1][32:23] !== 10'd22) begin
        n_fail++;
        $display("[TB] FAIL wrap_order: x got %0d,%0d required 11,22",
                 obs_q[0][32:23], obs_q[1][32:23]);
      end
    end
  endtask

  task automatic test_stall();
    logic [32:0] held;
    int cyc; bit to;
    clear_table();
    ram[14] = make_y(50, 1, 0, 1, 3, 2, 5);
    ram[15] = make_x(777, 9, 12, 1, 30);
    model_scan(60, 0);
    cmd_ready = 1'b0;
    start_line(60, 0);
    wait_valid(to);
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL stall_valid: cmd_valid never rose"); end
    held = cur_cmd;
    n_checks++;
    if (held !== exp_q[0]) begin
      n_fail++;
      $display("[TB] FAIL stall_fields: got %h required %h", held, exp_q[0]);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (!cmd_valid || cur_cmd !== held || hit_count !== '0) begin
        n_fail++;
        $display("[TB] FAIL stall_hold[%0d]: valid=%0d cmd=%h hit_count=%0d required 1/%h/0",
                 c, cmd_valid, cur_cmd, hit_count, held);
      end
    end
    @(posedge clk); #1;
    scan_en = 1'b0;
    cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (!cmd_valid || hit_count !== '0) begin
      n_fail++;
      $display("[TB] FAIL freeze: valid=%0d hit_count=%0d required 1/0", cmd_valid, hit_count);
    end
    @(posedge clk); #1;
    scan_en = 1'b1;
    wait_done(0, cyc, to);
    n_checks++;
    if (to || obs_q.size() != 1 || hit_count !== HCW'(1) || stable_errs != 0) begin
      n_fail++;
      $display("[TB] FAIL stall_release: commands=%0d hit_count=%0d field_changes=%0d required 1/1/0",
               obs_q.size(), hit_count, stable_errs);
    end
  endtask

  task automatic test_restart();
    int cyc; bit to;
    gen_table(200);
    ram[2*10]   = make_y(195, 1, 0, 0, 0, 0, 0);
    ram[2*10+1] = make_x(5, 0, 0, 0, 0);
    cmd_ready = 1'b0;
    start_line(200, 10);
    wait_valid(to);
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL restart_valid: cmd_valid never rose"); end
    model_scan(203, 77);
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    line_y = YW'(203);
    prio_start = IW'(77);
    line_start = 1'b1;
    obs_q.delete();
    @(posedge clk); #1;
    line_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cmd_valid, busy, done, overflow, hit_count} !== {1'b0, 1'b1, 1'b0, 1'b0, HCW'(0)}) begin
      n_fail++;
      $display("[TB] FAIL restart_state: valid=%0d busy=%0d done=%0d overflow=%0d hit_count=%0d required 0/1/0/0/0",
               cmd_valid, busy, done, overflow, hit_count);
    end
    wait_done(1, cyc, to);
    n_checks++;
    if (to || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL restart_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("[TB] FAIL restart_cmd[%0d]: got %h required %h", k, obs_q[k], exp_q[k]);
      end
    end
    start_line(203, 77);
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (all_out !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL rst_midscan: outputs=%h required=0", all_out);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_out !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL rst_after: outputs=%h required=0", all_out);
    end
  endtask

  task automatic test_random();
    int ly, prio, cyc; bit to;
    for (int it = 0; it < 6; it++) begin
      ly   = int'($urandom_range(0, (1 << YW) - 1));
      prio = int'($urandom_range(0, SC-1));
      gen_table(ly);
      model_scan(ly, prio);
      start_line(ly, prio);
      wait_done(1, cyc, to);
      n_checks++;
      if (to || obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_count: got %0d required %0d (timeout=%0d)",
                 it, obs_q.size(), exp_q.size(), to);
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
        n_checks++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("[TB] FAIL rand%0d_cmd[%0d]: got %h required %h", it, k, obs_q[k], exp_q[k]);
        end
      end
      n_checks++;
      if (overflow !== exp_ovf || hit_count !== HCW'(exp_q.size())) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_status: overflow=%0d hit_count=%0d required %0d/%0d",
                 it, overflow, hit_count, exp_ovf, exp_q.size());
      end
    end
    n_checks++;
    if (stable_errs != 0) begin
      n_fail++;
      $display("[TB] FAIL cmd_stability: %0d field changes while stalled, required 0", stable_errs);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_vflip();
    test_overflow();
    test_wrap();
    test_stall();
    test_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
